dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word-addressed little-endian RAM behind a request/ready
// handshake with a fixed number of wait states and byte/half/word load-store lanes.
module dmem_ctrl #(
  parameter int DEPTH = 128,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  dmtype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Access-type decode: 1 when the access is misaligned or the type is reserved.
  function automatic logic access_err(input logic [2:0] t, input logic [1:0] off);
    logic e_v;
    case (t)
      3'd0:       e_v = (off != 2'd0);
      3'd1, 3'd2: e_v = off[0];
      3'd3, 3'd4: e_v = 1'b0;
      default:    e_v = 1'b1;
    endcase
    return e_v;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] t,
                                           input logic [1:0] off);
    logic [7:0]  b_v;
    logic [15:0] h_v;
    logic [31:0] r_v;
    case (off)
      2'd0:    b_v = word[7:0];
      2'd1:    b_v = word[15:8];
      2'd2:    b_v = word[23:16];
      default: b_v = word[31:24];
    endcase
    h_v = off[1] ? word[31:16] : word[15:0];
    case (t)
      3'd0:    r_v = word;
      3'd1:    r_v = {{16{h_v[15]}}, h_v};
      3'd2:    r_v = {16'h0000, h_v};
      3'd3:    r_v = {{24{b_v[7]}}, b_v};
      3'd4:    r_v = {24'h000000, b_v};
      default: r_v = 32'h0000_0000;
    endcase
    return r_v;
  endfunction

  // Merges LSB-aligned store data into the old word; untouched lanes keep their value.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] t, input logic [1:0] off);
    logic [31:0] mask_v;
    logic [31:0] rep_v;
    case (t)
      3'd0: begin
        mask_v = 32'hFFFF_FFFF;
        rep_v  = wd;
      end
      3'd1, 3'd2: begin
        mask_v = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        rep_v  = {2{wd[15:0]}};
      end
      3'd3, 3'd4: begin
        case (off)
          2'd0:    mask_v = 32'h0000_00FF;
          2'd1:    mask_v = 32'h0000_FF00;
          2'd2:    mask_v = 32'h00FF_0000;
          default: mask_v = 32'hFF00_0000;
        endcase
        rep_v = {4{wd[7:0]}};
      end
      default: begin
        mask_v = 32'h0000_0000;
        rep_v  = 32'h0000_0000;
      end
    endcase
    return (old & ~mask_v) | (rep_v & mask_v);
  endfunction

  logic [31:0]   mem_r [DEPTH];
  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [2:0]    dmtype_r;
  logic [AW+1:0] addr_r;
  logic [31:0]   wdata_r;

  logic          acc_we_s;
  logic [2:0]    acc_type_s;
  logic [AW+1:0] acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [AW-1:0] acc_idx_s;
  logic          acc_err_s;
  logic [31:0]   mem_word_s;
  logic [31:0]   rdata_next_s;
  logic          enter_done_s;
  logic          addr_unused_s;

  assign addr_unused_s = &{1'b0, addr[31:AW+2]};

  // With WAIT=0 the access enters DONE straight from IDLE, so the live inputs are used there.
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_we_s    = we;
      acc_type_s  = dmtype;
      acc_addr_s  = addr[AW+1:0];
      acc_wdata_s = wdata;
    end else begin
      acc_we_s    = we_r;
      acc_type_s  = dmtype_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  assign acc_idx_s  = acc_addr_s[AW+1:2];
  assign acc_err_s  = access_err(acc_type_s, acc_addr_s[1:0]);
  assign mem_word_s = mem_r[acc_idx_s];

  // Result presented on DONE entry: zero on error, hold on store, extended lanes on load.
  always_comb begin
    if (acc_err_s) begin
      rdata_next_s = 32'h0000_0000;
    end else if (acc_we_s) begin
      rdata_next_s = rdata;
    end else begin
      rdata_next_s = load_ext(mem_word_s, acc_type_s, acc_addr_s[1:0]);
    end
  end

  // Marks the edge that moves the FSM into DONE; reset suppresses it.
  always_comb begin
    enter_done_s = 1'b0;
    if (reset) begin
      enter_done_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      enter_done_s = req && (WAIT == 0);
    end else if (state_r == ST_WAIT) begin
      enter_done_s = (cnt_r == 4'd0);
    end else begin
      enter_done_s = 1'b0;
    end
  end

  // Storage array: not reset, written only by an error-free store entering DONE.
  always_ff @(posedge clk) begin
    if (enter_done_s && acc_we_s && !acc_err_s) begin
      mem_r[acc_idx_s] <= store_merge(mem_word_s, acc_wdata_s, acc_type_s, acc_addr_s[1:0]);
    end
  end

  // Access FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      dmtype_r <= 3'd0;
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
      rdata    <= 32'h0000_0000;
      ready    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (req) begin
            we_r     <= we;
            dmtype_r <= dmtype;
            addr_r   <= addr[AW+1:0];
            wdata_r  <= wdata;
            busy     <= 1'b1;
            if (WAIT == 0) begin
              state_r <= ST_DONE;
              ready   <= 1'b1;
              err     <= acc_err_s;
              rdata   <= rdata_next_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_DONE;
            ready   <= 1'b1;
            err     <= acc_err_s;
            rdata   <= rdata_next_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready   <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          ready   <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (WAIT=1, WAIT=0, WAIT=3) sharing
// clock, reset and access fields, each with its own request line.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  dmtype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req0, req1, req3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ready0, ready1, ready3;
  logic        err0, err1, err3;
  logic        busy0, busy1, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(128), .WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .dmtype(dmtype), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1)
  );
  dmem_ctrl #(.DEPTH(128), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .dmtype(dmtype), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );
  dmem_ctrl #(.DEPTH(128), .WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .dmtype(dmtype), .addr(addr),
    .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3), .busy(busy3)
  );

  // One access on instance sel; lat counts edges from the accepting edge to ready.
  task automatic access(input int sel, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic pulse_ok);
    logic r, er, got;
    logic [31:0] rv;
    @(negedge clk);
    we = w; dmtype = t; addr = a; wdata = d;
    case (sel)
      0:       req0 = 1'b1;
      3:       req3 = 1'b1;
      default: req1 = 1'b1;
    endcase
    lat = 0; rd = 32'h0; e = 1'b0; pulse_ok = 1'b1; got = 1'b0;
    for (int i = 0; i < 32 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
      end
      lat++;
      case (sel)
        0:       begin r = ready0; er = err0; rv = rdata0; end
        3:       begin r = ready3; er = err3; rv = rdata3; end
        default: begin r = ready1; er = err1; rv = rdata1; end
      endcase
      if (!r && er) pulse_ok = 1'b0;
      if (r) begin
        rd = rv; e = er; got = 1'b1;
      end
    end
    if (!got) lat = 99;
    @(posedge clk); #1;
    case (sel)
      0:       r = ready0;
      3:       r = ready3;
      default: r = ready1;
    endcase
    if (r) pulse_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req1 = 1'b1; req0 = 1'b0; req3 = 1'b0;
    we = 1'b0; dmtype = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready1); end
    checks++; if (err1 !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", err1); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata1); end
    @(negedge clk);
    req1 = 1'b0; reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e, p; int lat;
    access(1, 1'b1, 3'd0, 32'h10, 32'h1234_5678, rd, e, lat, p);
    checks++; if (lat != 2 || e !== 1'b0 || !p) begin errors++; $display("FAIL word_store lat %0d err %b pulse %b want 2 0 1", lat, e, p); end
    access(1, 1'b0, 3'd0, 32'h10, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'h1234_5678 || e !== 1'b0) begin errors++; $display("FAIL word_load got %h err %b want 12345678 0", rd, e); end
    checks++; if (lat != 2 || !p) begin errors++; $display("FAIL word_load_lat got %0d pulse %b want 2 1", lat, p); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e, p; int lat;
    access(1, 1'b1, 3'd3, 32'h13, 32'hDEAD_BEAB, rd, e, lat, p);
    access(1, 1'b0, 3'd3, 32'h13, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'hFFFF_FFAB || e !== 1'b0) begin errors++; $display("FAIL byte_signed got %h want ffffffab", rd); end
    access(1, 1'b0, 3'd4, 32'h13, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL byte_unsigned got %h want 000000ab", rd); end
    access(1, 1'b0, 3'd0, 32'h10, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'hAB34_5678) begin errors++; $display("FAIL byte_merge got %h want ab345678", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic e, p; int lat;
    access(1, 1'b1, 3'd0, 32'h20, 32'hCAFE_BABE, rd, e, lat, p);
    access(1, 1'b1, 3'd1, 32'h22, 32'h5555_8001, rd, e, lat, p);
    access(1, 1'b0, 3'd1, 32'h22, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'hFFFF_8001 || e !== 1'b0) begin errors++; $display("FAIL half_signed got %h want ffff8001", rd); end
    access(1, 1'b0, 3'd2, 32'h22, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL half_unsigned got %h want 00008001", rd); end
    access(1, 1'b0, 3'd0, 32'h20, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'h8001_BABE) begin errors++; $display("FAIL half_merge got %h want 8001babe", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e, p; int lat;
    access(1, 1'b1, 3'd0, 32'h11, 32'hFFFF_FFFF, rd, e, lat, p);
    checks++; if (e !== 1'b1 || rd !== 32'h0 || !p) begin errors++; $display("FAIL err_word_store err %b rdata %h pulse %b want 1 0 1", e, rd, p); end
    access(1, 1'b0, 3'd0, 32'h10, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'hAB34_5678 || e !== 1'b0) begin errors++; $display("FAIL err_no_write got %h want ab345678", rd); end
    access(1, 1'b0, 3'd1, 32'h21, 32'h0, rd, e, lat, p);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_half_load err %b rdata %h want 1 0", e, rd); end
    access(1, 1'b0, 3'd7, 32'h10, 32'h0, rd, e, lat, p);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_type7 err %b rdata %h want 1 0", e, rd); end
    access(1, 1'b0, 3'd0, 32'h10, 32'h0, rd, e, lat, p);
    access(1, 1'b1, 3'd0, 32'h30, 32'h0000_0001, rd, e, lat, p);
    checks++; if (rd !== 32'hAB34_5678 || e !== 1'b0) begin errors++; $display("FAIL store_hold got %h want ab345678", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic e, p; int lat;
    access(1, 1'b1, 3'd0, 32'h204, 32'h0BAD_F00D, rd, e, lat, p);
    access(1, 1'b0, 3'd0, 32'h004, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'h0BAD_F00D || e !== 1'b0) begin errors++; $display("FAIL wrap got %h want 0badf00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e, p; int lat, cnt;
    logic [7:0] pat;
    access(0, 1'b1, 3'd0, 32'h8, 32'h5A5A_1234, rd, e, lat, p);
    checks++; if (lat != 1 || !p) begin errors++; $display("FAIL wait0_lat got %0d pulse %b want 1 1", lat, p); end
    @(negedge clk);
    we = 1'b0; dmtype = 3'd0; addr = 32'h8; req0 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      pat[i] = ready0;
      if (ready0) cnt++;
    end
    req0 = 1'b0;
    checks++; if (cnt != 4 || pat !== 8'b0101_0101) begin errors++; $display("FAIL b2b_pattern got %b count %0d want 01010101 4", pat, cnt); end
    checks++; if (rdata0 !== 32'h5A5A_1234) begin errors++; $display("FAIL b2b_rdata got %h want 5a5a1234", rdata0); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e, p; int lat;
    logic seen;
    access(3, 1'b1, 3'd0, 32'h40, 32'h1111_1111, rd, e, lat, p);
    checks++; if (lat != 4 || !p) begin errors++; $display("FAIL wait3_lat got %0d pulse %b want 4 1", lat, p); end
    access(3, 1'b0, 3'd0, 32'h40, 32'h0, rd, e, lat, p);
    @(negedge clk);
    we = 1'b1; dmtype = 3'd0; addr = 32'h40; wdata = 32'h2222_2222; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL abort_busy_wait got %b want 1", busy3); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready3 !== 1'b0 || busy3 !== 1'b0 || err3 !== 1'b0 || rdata3 !== 32'h0) begin
      errors++; $display("FAIL abort_outputs ready %b busy %b err %b rdata %h want 0 0 0 0", ready3, busy3, err3, rdata3);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready3) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready got %b want 0", seen); end
    access(3, 1'b0, 3'd0, 32'h40, 32'h0, rd, e, lat, p);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_no_write got %h want 11111111", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
